// File: rtl/sram_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_fifo_arbiter
// Brief    : Runs a pipelined ZBT SSRAM as one circular 16-bit FIFO with a
//            round-robin write/read command arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module sram_fifo_arbiter #(
    parameter int ADDR_WIDTH = 20
) (
    input  logic                  BUS_CLK,
    input  logic                  BUS_RST,
    input  logic                  ENABLE,
    input  logic                  WR_REQ,
    input  logic [15:0]           WR_DATA,
    output logic                  WR_ACK,
    input  logic                  RD_REQ,
    output logic                  RD_ACK,
    output logic                  RD_VALID,
    output logic [15:0]           RD_DATA,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [ADDR_WIDTH:0]   SIZE,
    output logic [22:0]           SRAM_ADD,
    output logic                  SRAM_ADV_LD_N,
    output logic                  SRAM_WE_N,
    output logic [1:0]            SRAM_BW_N,
    output logic                  SRAM_OE_N,
    output logic [15:0]           SRAM_DQ_OUT,
    output logic                  SRAM_DQ_OE,
    input  logic [15:0]           SRAM_DQ_IN
);

    localparam logic [ADDR_WIDTH:0] c_DEPTH       = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [0:0]          c_GRANT_WRITE = 1'b0;
    localparam logic [0:0]          c_GRANT_READ  = 1'b1;

    // Pointers, fill level and arbitration history
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   size_q, size_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic [0:0]            last_grant_q, last_grant_d;

    // SRAM command bus
    logic [22:0]           sram_add_q, sram_add_d;
    logic                  adv_ld_n_q, adv_ld_n_d;
    logic                  we_n_q, we_n_d;
    logic [1:0]            bw_n_q, bw_n_d;

    // Write-data pipeline: grant -> stage1 -> stage2 -> DQ drive
    logic                  wpipe1_vld_q, wpipe1_vld_d;
    logic [15:0]           wpipe1_data_q, wpipe1_data_d;
    logic                  wpipe2_vld_q, wpipe2_vld_d;
    logic [15:0]           wpipe2_data_q, wpipe2_data_d;
    logic                  dq_oe_q, dq_oe_d;
    logic [15:0]           dq_out_q, dq_out_d;

    // Read-data pipeline: grant -> stage1 -> stage2 -> OE cycle -> capture
    logic                  rpipe1_vld_q, rpipe1_vld_d;
    logic                  rpipe2_vld_q, rpipe2_vld_d;
    logic                  oe_n_q, oe_n_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [15:0]           rd_data_q, rd_data_d;

    // Arbitration
    logic [1:0]            wr_pend;
    logic [ADDR_WIDTH:0]   rd_avail;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  grant_wr;
    logic                  grant_rd;
    logic [22:0]           addr_ext;

    // Words granted for write in the last two cycles are not yet in the SRAM
    // array when a read issued now would fetch them, so they are not readable.
    always_comb begin
        wr_pend  = {1'b0, wpipe1_vld_q} + {1'b0, wpipe2_vld_q};
        rd_avail = size_q - {{(ADDR_WIDTH-1){1'b0}}, wr_pend};
        wr_ok    = ENABLE & WR_REQ & ~full_q & ~BUS_RST;
        rd_ok    = ENABLE & RD_REQ & (rd_avail != '0) & ~BUS_RST;
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (wr_ok && rd_ok) begin
            grant_wr = (last_grant_q == c_GRANT_READ);
            grant_rd = (last_grant_q == c_GRANT_WRITE);
        end else begin
            grant_wr = wr_ok;
            grant_rd = rd_ok;
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        size_d       = size_q;
        last_grant_d = last_grant_q;
        if (grant_wr) begin
            wr_ptr_d     = wr_ptr_q + 1'b1;
            size_d       = size_q + 1'b1;
            last_grant_d = c_GRANT_WRITE;
        end else if (grant_rd) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            size_d       = size_q - 1'b1;
            last_grant_d = c_GRANT_READ;
        end
        full_d  = (size_d == c_DEPTH);
        empty_d = (size_d == '0);
    end

    always_comb begin
        addr_ext                   = '0;
        addr_ext[ADDR_WIDTH-1:0]   = grant_wr ? wr_ptr_q : rd_ptr_q;
        sram_add_d                 = sram_add_q;
        adv_ld_n_d                 = 1'b1;
        we_n_d                     = 1'b1;
        bw_n_d                     = 2'b11;
        if (grant_wr || grant_rd) begin
            sram_add_d = addr_ext;
            adv_ld_n_d = 1'b0;
        end
        if (grant_wr) begin
            we_n_d = 1'b0;
            bw_n_d = 2'b00;
        end
    end

    always_comb begin
        wpipe1_vld_d  = grant_wr;
        wpipe1_data_d = grant_wr ? WR_DATA : wpipe1_data_q;
        wpipe2_vld_d  = wpipe1_vld_q;
        wpipe2_data_d = wpipe1_data_q;
        dq_oe_d       = wpipe2_vld_q;
        dq_out_d      = wpipe2_vld_q ? wpipe2_data_q : dq_out_q;
    end

    // SRAM drives read data during the OE cycle; it is captured at its end.
    always_comb begin
        rpipe1_vld_d = grant_rd;
        rpipe2_vld_d = rpipe1_vld_q;
        oe_n_d       = ~rpipe2_vld_q;
        rd_valid_d   = ~oe_n_q;
        rd_data_d    = ~oe_n_q ? SRAM_DQ_IN : rd_data_q;
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            size_q        <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            last_grant_q  <= c_GRANT_READ;
            sram_add_q    <= '0;
            adv_ld_n_q    <= 1'b1;
            we_n_q        <= 1'b1;
            bw_n_q        <= 2'b11;
            wpipe1_vld_q  <= 1'b0;
            wpipe1_data_q <= '0;
            wpipe2_vld_q  <= 1'b0;
            wpipe2_data_q <= '0;
            dq_oe_q       <= 1'b0;
            dq_out_q      <= '0;
            rpipe1_vld_q  <= 1'b0;
            rpipe2_vld_q  <= 1'b0;
            oe_n_q        <= 1'b1;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            size_q        <= size_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            last_grant_q  <= last_grant_d;
            sram_add_q    <= sram_add_d;
            adv_ld_n_q    <= adv_ld_n_d;
            we_n_q        <= we_n_d;
            bw_n_q        <= bw_n_d;
            wpipe1_vld_q  <= wpipe1_vld_d;
            wpipe1_data_q <= wpipe1_data_d;
            wpipe2_vld_q  <= wpipe2_vld_d;
            wpipe2_data_q <= wpipe2_data_d;
            dq_oe_q       <= dq_oe_d;
            dq_out_q      <= dq_out_d;
            rpipe1_vld_q  <= rpipe1_vld_d;
            rpipe2_vld_q  <= rpipe2_vld_d;
            oe_n_q        <= oe_n_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign WR_ACK        = grant_wr;
    assign RD_ACK        = grant_rd;
    assign RD_VALID      = rd_valid_q;
    assign RD_DATA       = rd_data_q;
    assign FULL          = full_q;
    assign EMPTY         = empty_q;
    assign SIZE          = size_q;
    assign SRAM_ADD      = sram_add_q;
    assign SRAM_ADV_LD_N = adv_ld_n_q;
    assign SRAM_WE_N     = we_n_q;
    assign SRAM_BW_N     = bw_n_q;
    assign SRAM_OE_N     = oe_n_q;
    assign SRAM_DQ_OUT   = dq_out_q;
    assign SRAM_DQ_OE    = dq_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_fifo_arbiter
// Brief    : Directed bench for sram_fifo_arbiter with a queue-based FIFO
//            model, a ZBT SRAM device model and per-cycle output comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_fifo_arbiter;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          BUS_RST = 1'b1;
    logic          ENABLE = 1'b1;
    logic          WR_REQ = 1'b0;
    logic [15:0]   WR_DATA = '0;
    logic          RD_REQ = 1'b0;
    logic          WR_ACK, RD_ACK, RD_VALID, FULL, EMPTY;
    logic [15:0]   RD_DATA;
    logic [AW:0]   SIZE;
    logic [22:0]   SRAM_ADD;
    logic          SRAM_ADV_LD_N, SRAM_WE_N, SRAM_OE_N, SRAM_DQ_OE;
    logic [1:0]    SRAM_BW_N;
    logic [15:0]   SRAM_DQ_OUT;
    logic [15:0]   SRAM_DQ_IN;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    sram_fifo_arbiter #(.ADDR_WIDTH(AW)) dut (
        .BUS_CLK       (clk),
        .BUS_RST       (BUS_RST),
        .ENABLE        (ENABLE),
        .WR_REQ        (WR_REQ),
        .WR_DATA       (WR_DATA),
        .WR_ACK        (WR_ACK),
        .RD_REQ        (RD_REQ),
        .RD_ACK        (RD_ACK),
        .RD_VALID      (RD_VALID),
        .RD_DATA       (RD_DATA),
        .FULL          (FULL),
        .EMPTY         (EMPTY),
        .SIZE          (SIZE),
        .SRAM_ADD      (SRAM_ADD),
        .SRAM_ADV_LD_N (SRAM_ADV_LD_N),
        .SRAM_WE_N     (SRAM_WE_N),
        .SRAM_BW_N     (SRAM_BW_N),
        .SRAM_OE_N     (SRAM_OE_N),
        .SRAM_DQ_OUT   (SRAM_DQ_OUT),
        .SRAM_DQ_OE    (SRAM_DQ_OE),
        .SRAM_DQ_IN    (SRAM_DQ_IN)
    );

    // ZBT device: command seen in cycle C, data on DQ during cycle C+2.
    bit [15:0] mem [DEPTH];
    bit        s1_v = 0, s1_we = 0, s2_v = 0, s2_we = 0;
    bit [3:0]  s1_a = 0, s2_a = 0;
    always @(posedge clk) begin
        if (s2_v && s2_we) mem[s2_a] <= SRAM_DQ_OUT;
        s2_v  <= s1_v;
        s2_we <= s1_we;
        s2_a  <= s1_a;
        s1_v  <= !SRAM_ADV_LD_N;
        s1_we <= !SRAM_WE_N;
        s1_a  <= SRAM_ADD[3:0];
    end
    assign SRAM_DQ_IN = (s2_v && !s2_we) ? mem[s2_a] : 16'hDEAD;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { logic [15:0] d; int c; } ent_t;
    ent_t        m_q[$];
    int          m_wp = 0, m_rp = 0;
    bit          m_last_rd = 1;
    int          m_cmd = 0;            // 0 idle, 1 write, 2 read
    logic [22:0] m_add = '0;
    bit          sch_dq_v [8];
    logic [15:0] sch_dq_d [8];
    bit          sch_oe   [8];
    bit          sch_rv   [8];
    logic [15:0] sch_rd   [8];
    int          mi;
    bit          m_wok, m_rok, m_gw, m_gr;
    ent_t        m_e;

    task automatic model_cycle();
        mi    = cyc % 8;
        m_wok = ENABLE && WR_REQ && (m_q.size() < DEPTH) && !BUS_RST;
        m_rok = 0;
        if (ENABLE && RD_REQ && !BUS_RST && m_q.size() > 0)
            m_rok = (m_q[0].c <= cyc - 3);
        m_gw = m_wok && (!m_rok || m_last_rd);
        m_gr = m_rok && !m_gw;

        check("WR_ACK", WR_ACK, m_gw);
        check("RD_ACK", RD_ACK, m_gr);
        check("SIZE", SIZE, m_q.size());
        check("FULL", FULL, m_q.size() == DEPTH);
        check("EMPTY", EMPTY, m_q.size() == 0);
        check("ADV_LD_N", SRAM_ADV_LD_N, m_cmd == 0);
        check("WE_N", SRAM_WE_N, m_cmd != 1);
        check("BW_N", SRAM_BW_N, (m_cmd == 1) ? 2'b00 : 2'b11);
        check("SRAM_ADD", SRAM_ADD, m_add);
        check("DQ_OE", SRAM_DQ_OE, sch_dq_v[mi]);
        if (sch_dq_v[mi]) check("DQ_OUT", SRAM_DQ_OUT, sch_dq_d[mi]);
        check("OE_N", SRAM_OE_N, !sch_oe[mi]);
        check("RD_VALID", RD_VALID, sch_rv[mi]);
        if (sch_rv[mi]) check("RD_DATA", RD_DATA, sch_rd[mi]);
        check("DQ bus clash", SRAM_DQ_OE && !SRAM_OE_N, 0);

        sch_dq_v[mi] = 0;
        sch_oe[mi]   = 0;
        sch_rv[mi]   = 0;
        if (BUS_RST) begin
            m_q.delete();
            m_wp = 0; m_rp = 0; m_last_rd = 1; m_cmd = 0; m_add = '0;
            for (int k = 0; k < 8; k++) begin
                sch_dq_v[k] = 0; sch_oe[k] = 0; sch_rv[k] = 0;
            end
        end else begin
            m_cmd = 0;
            if (m_gw) begin
                m_e.d = WR_DATA;
                m_e.c = cyc;
                m_q.push_back(m_e);
                m_cmd = 1;
                m_add = 23'(m_wp);
                m_wp  = (m_wp + 1) % DEPTH;
                sch_dq_v[(cyc + 3) % 8] = 1;
                sch_dq_d[(cyc + 3) % 8] = WR_DATA;
                m_last_rd = 0;
            end else if (m_gr) begin
                m_e   = m_q.pop_front();
                m_cmd = 2;
                m_add = 23'(m_rp);
                m_rp  = (m_rp + 1) % DEPTH;
                sch_oe[(cyc + 3) % 8] = 1;
                sch_rv[(cyc + 4) % 8] = 1;
                sch_rd[(cyc + 4) % 8] = m_e.d;
                m_last_rd = 1;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input int which, input int limit, output int t);
        bit found;
        found = 0;
        t     = 0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if ((which == 0 && RD_ACK) || (which == 1 && RD_VALID)) begin
                t = cyc;
                found = 1;
                break;
            end
        end
        check("wait bound", found, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before 100us");
        $fatal(1);
    end

    int t_w, t_r, t_v, nval;
    logic [15:0] first_d, last_d;

    initial begin
        fork
            forever begin
                @(negedge clk);
                model_cycle();
            end
        join_none

        // Reset
        repeat (3) @(posedge clk);
        #1;
        BUS_RST = 0;
        @(negedge clk);
        check("rst EMPTY", EMPTY, 1);
        check("rst SIZE", SIZE, 0);
        check("rst ADV_LD_N", SRAM_ADV_LD_N, 1);
        check("rst BW_N", SRAM_BW_N, 2'b11);
        check("rst RD_VALID", RD_VALID, 0);
        check("rst RD_DATA", RD_DATA, 0);
        check("rst DQ_OUT", SRAM_DQ_OUT, 0);
        tick();

        // Single word
        WR_REQ = 1; RD_REQ = 1; WR_DATA = 16'hA5A5;
        @(negedge clk);
        check("single WR_ACK", WR_ACK, 1);
        t_w = cyc;
        tick();
        WR_REQ = 0; WR_DATA = 16'h0;
        @(negedge clk);
        check("single cmd ADD", SRAM_ADD, 0);
        check("single cmd WE_N", SRAM_WE_N, 0);
        wait_for(0, 8, t_r);
        check("single RAW gap", t_r - t_w, 3);
        wait_for(1, 8, t_v);
        check("single rd latency", t_v - t_r, 4);
        check("single RD_DATA", RD_DATA, 16'hA5A5);
        tick();
        RD_REQ = 0;

        // Contention: prime to 11 words, drop one so the next winner is write
        for (int k = 0; k < 11; k++) begin
            WR_REQ = 1; WR_DATA = 16'h1000 + 16'(k);
            tick();
        end
        WR_REQ = 0; RD_REQ = 1;
        @(negedge clk);
        check("prime RD_ACK", RD_ACK, 1);
        tick();
        for (int k = 0; k < 20; k++) begin
            WR_REQ = 1; RD_REQ = 1; WR_DATA = 16'h2000 + 16'(k);
            @(negedge clk);
            check("alt WR_ACK", WR_ACK, (k % 2) == 0);
            check("alt RD_ACK", RD_ACK, (k % 2) == 1);
            check("alt SIZE range", (SIZE >= 10) && (SIZE <= 11), 1);
            tick();
        end
        WR_REQ = 0; RD_REQ = 1;
        repeat (25) tick();
        RD_REQ = 0;
        @(negedge clk);
        check("drain EMPTY", EMPTY, 1);
        tick();

        // Full and wrap from a clean reset
        BUS_RST = 1;
        repeat (3) tick();
        BUS_RST = 0;
        for (int k = 0; k < 16; k++) begin
            WR_REQ = 1; WR_DATA = 16'(k);
            tick();
        end
        WR_DATA = 16'hBEEF;
        @(negedge clk);
        check("full FULL", FULL, 1);
        check("full SIZE", SIZE, 16);
        check("full WR_ACK", WR_ACK, 0);
        tick();
        @(negedge clk);
        check("full WR_ACK held", WR_ACK, 0);
        tick();
        WR_REQ = 0; RD_REQ = 1;
        @(negedge clk);
        check("wrap RD_ACK", RD_ACK, 1);
        tick();
        RD_REQ = 0; WR_REQ = 1; WR_DATA = 16'h0077;
        @(negedge clk);
        check("wrap WR_ACK", WR_ACK, 1);
        tick();
        WR_REQ = 0;
        @(negedge clk);
        check("wrap ADD", SRAM_ADD, 0);
        check("wrap WE_N", SRAM_WE_N, 0);
        tick();
        RD_REQ = 1;
        nval = 0; first_d = 16'hFFFF; last_d = 16'hFFFF;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (RD_VALID) begin
                if (nval == 0) first_d = RD_DATA;
                last_d = RD_DATA;
                nval++;
            end
            tick();
        end
        RD_REQ = 0;
        check("wrap word count", nval, 17);
        check("wrap first word", first_d, 16'h0000);
        check("wrap last word", last_d, 16'h0077);

        // Empty FIFO and read-after-write spacing
        RD_REQ = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("empty RD_ACK", RD_ACK, 0);
            tick();
        end
        WR_REQ = 1; WR_DATA = 16'h5A5A;
        @(negedge clk);
        check("raw WR_ACK", WR_ACK, 1);
        check("raw RD_ACK T", RD_ACK, 0);
        tick();
        WR_REQ = 0;
        @(negedge clk);
        check("raw RD_ACK T+1", RD_ACK, 0);
        tick();
        @(negedge clk);
        check("raw RD_ACK T+2", RD_ACK, 0);
        tick();
        @(negedge clk);
        check("raw RD_ACK T+3", RD_ACK, 1);
        tick();
        repeat (6) tick();
        RD_REQ = 0;

        // ENABLE drops with writes in flight
        WR_REQ = 1; WR_DATA = 16'h0E01;
        tick();
        WR_DATA = 16'h0E02;
        tick();
        ENABLE = 0; RD_REQ = 1; WR_DATA = 16'h0E03;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("disabled WR_ACK", WR_ACK, 0);
            check("disabled RD_ACK", RD_ACK, 0);
            tick();
        end
        ENABLE = 1; WR_REQ = 0;
        repeat (10) tick();
        RD_REQ = 0;

        // Reset with three reads in flight
        for (int k = 0; k < 5; k++) begin
            WR_REQ = 1; WR_DATA = 16'h3000 + 16'(k);
            tick();
        end
        WR_REQ = 0;
        repeat (3) tick();
        RD_REQ = 1;
        repeat (3) tick();
        RD_REQ = 0; BUS_RST = 1;
        tick();
        @(negedge clk);
        check("midrst RD_VALID", RD_VALID, 0);
        check("midrst SIZE", SIZE, 0);
        check("midrst EMPTY", EMPTY, 1);
        check("midrst ADV_LD_N", SRAM_ADV_LD_N, 1);
        tick();
        BUS_RST = 0; RD_REQ = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post rst RD_ACK", RD_ACK, 0);
            check("post rst ADV_LD_N", SRAM_ADV_LD_N, 1);
            check("post rst RD_VALID", RD_VALID, 0);
            tick();
        end
        RD_REQ = 0;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
